// File: rtl/bram_req_pkg.sv
// Shared sizing helpers for the BRAM request server and its response FIFO.
package bram_req_pkg;

    function automatic int lat(input int pipelined);
        return (pipelined != 0) ? 2 : 1;
    endfunction

    function automatic int credit_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/bram_rsp_fifo.sv
// In-order response FIFO with wrap-around pointers and an occupancy count.
module bram_rsp_fifo
    import bram_req_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
) (
    input  logic                       CLK,
    input  logic                       RST_N,
    input  logic                       wr_en,
    input  logic [DATA_WIDTH-1:0]      wr_data,
    input  logic                       rd_en,
    output logic [DATA_WIDTH-1:0]      rd_data,
    output logic [credit_w(DEPTH)-1:0] count
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = credit_w(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic                  do_rd;

    assign do_rd   = rd_en && (count != '0);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PW'(1);
            if (do_rd) rd_ptr <= rd_ptr + PW'(1);
            if (wr_en && !do_rd)
                count <= count + CW'(1);
            else if (!wr_en && do_rd)
                count <= count - CW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

`ifndef SYNTHESIS
    // Credits guarantee space; a push into a full FIFO means the credit logic is broken.
    always_ff @(posedge CLK) begin
        if (RST_N) assert (!(wr_en && !do_rd && count == CW'(DEPTH)));
    end
`endif

endmodule

// File: rtl/bram_req_server.sv
// Valid/ready front end for one BRAM port with credit-based response buffering.
// Optional macro BRAM_REQ_SERVER_WRITE_ACK_EN: writes also return the merged word as an ack.
module bram_req_server
    import bram_req_pkg::*;
#(
    parameter int ADDR_WIDTH = 1,
    parameter int DATA_WIDTH = 8,
    parameter int CHUNKSIZE  = 8,
    parameter int WE_WIDTH   = 1,
    parameter int PIPELINED  = 0,
    parameter int RSP_DEPTH  = 4
) (
    input  logic                           CLK,
    input  logic                           RST_N,
    input  logic                           REQ_VALID,
    output logic                           REQ_READY,
    input  logic [WE_WIDTH-1:0]            REQ_WE,
    input  logic [ADDR_WIDTH-1:0]          REQ_ADDR,
    input  logic [DATA_WIDTH-1:0]          REQ_DATA,
    output logic                           RSP_VALID,
    input  logic                           RSP_READY,
    output logic [DATA_WIDTH-1:0]          RSP_DATA,
    output logic [credit_w(RSP_DEPTH)-1:0] CREDITS,
    output logic                           BRAM_EN,
    output logic [WE_WIDTH-1:0]            BRAM_WE,
    output logic [ADDR_WIDTH-1:0]          BRAM_ADDR,
    output logic [DATA_WIDTH-1:0]          BRAM_DI,
    input  logic [DATA_WIDTH-1:0]          BRAM_DO
);

    localparam int L  = lat(PIPELINED);
    localparam int CW = credit_w(RSP_DEPTH);

    if (DATA_WIDTH != WE_WIDTH * CHUNKSIZE) begin : g_bad_width
        $error("DATA_WIDTH must equal WE_WIDTH*CHUNKSIZE");
    end

    logic          accept;
    logic          rsp_gen;
    logic          deq;
    logic [CW-1:0] credits;
    logic [CW-1:0] fifo_count;
    logic [L-1:0]  expect_sr;

    assign REQ_READY = RST_N && (credits != '0);
    assign accept    = REQ_VALID && REQ_READY;

`ifdef BRAM_REQ_SERVER_WRITE_ACK_EN
    assign rsp_gen = accept;
`else
    assign rsp_gen = accept && (REQ_WE == '0);
`endif

    assign BRAM_EN   = accept;
    assign BRAM_WE   = accept ? REQ_WE : '0;
    assign BRAM_ADDR = REQ_ADDR;
    assign BRAM_DI   = REQ_DATA;

    assign RSP_VALID = (fifo_count != '0);
    assign deq       = RSP_VALID && RSP_READY;
    assign CREDITS   = credits;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            credits   <= CW'(RSP_DEPTH);
            expect_sr <= '0;
        end else begin
            if (rsp_gen && !deq)
                credits <= credits - CW'(1);
            else if (!rsp_gen && deq)
                credits <= credits + CW'(1);
            // Tail bit marks the cycle in which BRAM_DO carries the requested word.
            expect_sr <= (expect_sr << 1) | L'(rsp_gen);
        end
    end

    bram_rsp_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (RSP_DEPTH)
    ) u_fifo (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .wr_en   (expect_sr[L-1]),
        .wr_data (BRAM_DO),
        .rd_en   (deq),
        .rd_data (RSP_DATA),
        .count   (fifo_count)
    );

`ifndef SYNTHESIS
    always_ff @(posedge CLK) begin
        if (RST_N) assert (32'(credits) + $countones(expect_sr) + 32'(fifo_count) == RSP_DEPTH);
    end
`endif

endmodule

// File: tb/tb_bram_req_server.sv
// Scoreboard bench: u0 is a PIPELINED=0 8-bit port, u1 a PIPELINED=1 16-bit two-lane port.
module tb_bram_req_server;

    typedef struct {
        logic [15:0] data;
        int          cyc;
    } exp_t;

`ifdef BRAM_REQ_SERVER_WRITE_ACK_EN
    localparam bit WACK = 1'b1;
`else
    localparam bit WACK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   acc0 = 0;
    exp_t q0[$];
    exp_t q1[$];

    logic        a_req_valid, a_req_ready, a_rsp_valid, a_rsp_ready, a_bram_en;
    logic [0:0]  a_req_we, a_bram_we;
    logic [3:0]  a_req_addr, a_bram_addr;
    logic [7:0]  a_req_data, a_rsp_data, a_bram_di, a_bram_do;
    logic [2:0]  a_credits;

    logic        b_req_valid, b_req_ready, b_rsp_valid, b_rsp_ready, b_bram_en;
    logic [1:0]  b_req_we, b_bram_we;
    logic [3:0]  b_req_addr, b_bram_addr;
    logic [15:0] b_req_data, b_rsp_data, b_bram_di, b_bram_do, b_do_int;
    logic [2:0]  b_credits;

    logic [7:0]  mem0 [16] = '{8'h40, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47,
                               8'h48, 8'h49, 8'h4A, 8'h4B, 8'h4C, 8'h4D, 8'h4E, 8'h4F};
    logic [15:0] mem1 [16] = '{16'hB000, 16'hB001, 16'hB002, 16'hB003, 16'hB004, 16'hB005,
                               16'hB006, 16'hB007, 16'hB008, 16'hB009, 16'hB00A, 16'hB00B,
                               16'hB00C, 16'hB00D, 16'hB00E, 16'hB00F};

    always #5 clk = ~clk;

    bram_req_server #(
        .ADDR_WIDTH(4), .DATA_WIDTH(8), .CHUNKSIZE(8), .WE_WIDTH(1), .PIPELINED(0), .RSP_DEPTH(4)
    ) u0 (
        .CLK(clk), .RST_N(rst_n),
        .REQ_VALID(a_req_valid), .REQ_READY(a_req_ready), .REQ_WE(a_req_we),
        .REQ_ADDR(a_req_addr), .REQ_DATA(a_req_data),
        .RSP_VALID(a_rsp_valid), .RSP_READY(a_rsp_ready), .RSP_DATA(a_rsp_data),
        .CREDITS(a_credits),
        .BRAM_EN(a_bram_en), .BRAM_WE(a_bram_we), .BRAM_ADDR(a_bram_addr),
        .BRAM_DI(a_bram_di), .BRAM_DO(a_bram_do)
    );

    bram_req_server #(
        .ADDR_WIDTH(4), .DATA_WIDTH(16), .CHUNKSIZE(8), .WE_WIDTH(2), .PIPELINED(1), .RSP_DEPTH(4)
    ) u1 (
        .CLK(clk), .RST_N(rst_n),
        .REQ_VALID(b_req_valid), .REQ_READY(b_req_ready), .REQ_WE(b_req_we),
        .REQ_ADDR(b_req_addr), .REQ_DATA(b_req_data),
        .RSP_VALID(b_rsp_valid), .RSP_READY(b_rsp_ready), .RSP_DATA(b_rsp_data),
        .CREDITS(b_credits),
        .BRAM_EN(b_bram_en), .BRAM_WE(b_bram_we), .BRAM_ADDR(b_bram_addr),
        .BRAM_DI(b_bram_di), .BRAM_DO(b_bram_do)
    );

    function automatic logic [15:0] merge16(input logic [15:0] old, input logic [15:0] di,
                                            input logic [1:0] we);
        return {we[1] ? di[15:8] : old[15:8], we[0] ? di[7:0] : old[7:0]};
    endfunction

    // Write-first RAM models: latency 1 for u0, latency 2 (output register) for u1.
    always @(posedge clk) begin
        if (a_bram_en) begin
            if (a_bram_we[0]) mem0[a_bram_addr] <= a_bram_di;
            a_bram_do <= a_bram_we[0] ? a_bram_di : mem0[a_bram_addr];
        end
    end

    always @(posedge clk) begin
        if (b_bram_en) begin
            mem1[b_bram_addr] <= merge16(mem1[b_bram_addr], b_bram_di, b_bram_we);
            b_do_int          <= merge16(mem1[b_bram_addr], b_bram_di, b_bram_we);
        end
        b_bram_do <= b_do_int;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
    endtask

    // Monitor: pops the scoreboard on every dequeue.
    always @(negedge clk) begin : mon
        exp_t e;
        if (a_bram_en) acc0++;
        if (a_rsp_valid && a_rsp_ready) begin
            if (q0.size() == 0) begin
                checks++; errors++;
                $display("FAIL u0 stale response: got %0h expected none", a_rsp_data);
            end else begin
                e = q0.pop_front();
                check("u0 rsp data", 32'(a_rsp_data), 32'(e.data));
                if (e.cyc >= 0) check("u0 rsp latency", cyc, e.cyc);
            end
        end
        if (b_rsp_valid && b_rsp_ready) begin
            if (q1.size() == 0) begin
                checks++; errors++;
                $display("FAIL u1 stale response: got %0h expected none", b_rsp_data);
            end else begin
                e = q1.pop_front();
                check("u1 rsp data", 32'(b_rsp_data), 32'(e.data));
                if (e.cyc >= 0) check("u1 rsp latency", cyc, e.cyc);
            end
        end
    end

    // Holds the request until accepted; returns #1 after the accepting edge.
    task automatic issue(input int u, input logic [3:0] addr, input logic [1:0] we,
                         input logic [15:0] data, input logic [15:0] exp,
                         input bit push, input bit exact);
        exp_t e;
        logic rdy;
        if (u == 0) begin
            a_req_valid = 1'b1; a_req_we = we[0]; a_req_addr = addr; a_req_data = data[7:0];
        end else begin
            b_req_valid = 1'b1; b_req_we = we; b_req_addr = addr; b_req_data = data;
        end
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            rdy = (u == 0) ? a_req_ready : b_req_ready;
            if (rdy) begin
                if (push) begin
                    e.data = exp;
                    e.cyc  = exact ? cyc + ((u == 0) ? 1 : 2) + 1 : -1;
                    if (u == 0) q0.push_back(e);
                    else        q1.push_back(e);
                end
                @(posedge clk); #1;
                return;
            end
            @(posedge clk); #1;
        end
        fail_now("issue accept");
    endtask

    task automatic idle();
        a_req_valid = 1'b0;
        b_req_valid = 1'b0;
    endtask

    task automatic wait_drain(input int u);
        for (int n = 0; n < 80; n++) begin
            if ((u == 0 ? q0.size() : q1.size()) == 0) break;
            @(posedge clk); #1;
        end
        if ((u == 0 ? q0.size() : q1.size()) != 0) fail_now("drain");
        @(posedge clk); #1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int base;
        logic [3:0] ad;
        rst_n = 1'b0;
        a_req_valid = 1'b1; a_req_we = '0; a_req_addr = '0; a_req_data = '0; a_rsp_ready = 1'b1;
        b_req_valid = 1'b1; b_req_we = '0; b_req_addr = '0; b_req_data = '0; b_rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset u0 rsp_valid", 32'(a_rsp_valid), 0);
        check("reset u0 req_ready", 32'(a_req_ready), 0);
        check("reset u0 bram_en", 32'(a_bram_en), 0);
        check("reset u0 credits", 32'(a_credits), 4);
        check("reset u1 credits", 32'(b_credits), 4);
        check("reset u1 req_ready", 32'(b_req_ready), 0);
        idle();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("u0 req_ready after reset", 32'(a_req_ready), 1);

        // Write then read back, PIPELINED=0.
        issue(0, 4'd3, 2'b01, 16'h00A5, 16'h00A5, WACK, 1'b1);
        issue(0, 4'd3, 2'b00, 16'h0000, 16'h00A5, 1'b1, 1'b1);
        idle();
        wait_drain(0);
        check("u0 credits after dequeue", 32'(a_credits), 4);

        // Lane-merged write then read, PIPELINED=1.
        issue(1, 4'd0, 2'b11, 16'h1234, 16'h1234, WACK, 1'b1);
        issue(1, 4'd0, 2'b01, 16'hFF66, 16'h1266, WACK, 1'b1);
        issue(1, 4'd0, 2'b00, 16'h0000, 16'h1266, 1'b1, 1'b1);
        idle();
        wait_drain(1);
        check("u1 credits after dequeue", 32'(b_credits), 4);

        // Back-pressure: six reads, only four fit.
        a_rsp_ready = 1'b0;
        base = acc0;
        for (int i = 0; i < 4; i++) begin
            ad = 4'(4 + i);
            issue(0, ad, 2'b00, 16'h0, 16'(8'h40 + ad), 1'b1, 1'b0);
        end
        a_req_valid = 1'b1; a_req_addr = 4'd8; a_req_we = '0;
        repeat (3) @(posedge clk);
        #1;
        check("stall req_ready", 32'(a_req_ready), 0);
        check("stall credits", 32'(a_credits), 0);
        check("stall accepted count", acc0 - base, 4);
        check("stall rsp_valid", 32'(a_rsp_valid), 1);
        a_rsp_ready = 1'b1;
        issue(0, 4'd8, 2'b00, 16'h0, 16'h0048, 1'b1, 1'b0);
        issue(0, 4'd9, 2'b00, 16'h0, 16'h0049, 1'b1, 1'b0);
        idle();
        wait_drain(0);
        check("u0 credits after burst", 32'(a_credits), 4);

        // Steady state at FIFO count 3: accept and dequeue every cycle.
        a_rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ad = 4'(10 + i);
            issue(0, ad, 2'b00, 16'h0, 16'(8'h40 + ad), 1'b1, 1'b0);
        end
        idle();
        repeat (4) @(posedge clk);
        #1;
        check("prefill credits", 32'(a_credits), 1);
        a_rsp_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            ad = 4'(4 + (i % 10));
            issue(0, ad, 2'b00, 16'h0, 16'(8'h40 + ad), 1'b1, 1'b0);
            check("steady credits", 32'(a_credits), 1);
        end
        idle();
        wait_drain(0);
        check("u0 credits after steady", 32'(a_credits), 4);

        // Reset with two responses queued and two reads in flight.
        b_rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ad = 4'(4 + i);
            issue(1, ad, 2'b00, 16'h0, 16'(16'hB000 + ad), 1'b1, 1'b0);
        end
        idle();
        check("pre-reset u1 credits", 32'(b_credits), 0);
        check("pre-reset u1 rsp_valid", 32'(b_rsp_valid), 1);
        rst_n = 1'b0;
        #1;
        check("mid reset u1 rsp_valid", 32'(b_rsp_valid), 0);
        check("mid reset u1 req_ready", 32'(b_req_ready), 0);
        q1.delete();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("post reset u1 credits", 32'(b_credits), 4);
        check("post reset u0 credits", 32'(a_credits), 4);
        b_rsp_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("post reset no stale", 32'(b_rsp_valid), 0);

        // Write credit behaviour (acknowledged only when the ack feature is built in).
        issue(0, 4'd1, 2'b01, 16'h005A, 16'h005A, WACK, 1'b1);
        check("write credits", 32'(a_credits), 32'(4 - int'(WACK)));
        idle();
        wait_drain(0);
        check("u0 credits final", 32'(a_credits), 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
